// File: rtl/scalar_product_acc_pkg.sv
// Shared width derivations and default sizing for the scalar-product datapath,
// reused by the multiplier wrapper and its bench.
package scalar_product_acc_pkg;

   localparam int DEF_NBITS  = 4;
   localparam int DEF_NLANES = 4;
   localparam int DEF_NBEATS = 2;

   // Ceiling log2; returns 0 for an argument of 1.
   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int part_w_f(input int nbits, input int nlanes);
      return 2 * nbits + clog2_f(nlanes);
   endfunction

   function automatic int acc_w_f(input int nbits, input int nlanes, input int nbeats);
      return 2 * nbits + clog2_f(nlanes * nbeats);
   endfunction

endpackage

// File: rtl/scalar_product_acc_lane_adder_tree.sv
// Combinational unsigned sum of NLANES packed lanes, full-width result.
module lane_adder_tree
   import scalar_product_acc_pkg::*;
#(
   parameter  int NLANES = DEF_NLANES,
   parameter  int LANE_W = 2 * DEF_NBITS,
   localparam int SUM_W  = LANE_W + clog2_f(NLANES)
) (
   input  logic [NLANES*LANE_W-1:0] i_lanes,
   output logic [SUM_W-1:0]         o_sum
);

   logic [SUM_W-1:0] w_sum;

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < NLANES; i++) begin
         w_sum = w_sum + SUM_W'(i_lanes[i*LANE_W +: LANE_W]);
      end
   end

   assign o_sum = w_sum;

endmodule

// File: rtl/scalar_product_acc.sv
// Two-stage accumulator: stage 1 reduces one beat of lane products, stage 2
// accumulates NBEATS partials into one scalar product with a held result.
module scalar_product_acc
   import scalar_product_acc_pkg::*;
#(
   parameter  int NBITS  = DEF_NBITS,
   parameter  int NLANES = DEF_NLANES,
   parameter  int NBEATS = DEF_NBEATS,
   localparam int PROD_W = 2 * NBITS,
   localparam int PART_W = part_w_f(NBITS, NLANES),
   localparam int ACC_W  = acc_w_f(NBITS, NLANES, NBEATS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NLANES*PROD_W-1:0] prod_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [ACC_W-1:0]         sum_out,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int CNT_W = (NBEATS > 1) ? clog2_f(NBEATS) : 1;

   // Handshake: a beat transfers on an edge where in_valid && in_ready; a
   // result transfers where out_valid && out_ready. Everything advances only
   // when the output register is empty or being drained (w_adv).
   logic              w_adv;
   logic              w_accept;
   logic              w_beat_last;
   logic              w_done;
   logic [PART_W-1:0] w_lane_sum;
   logic [ACC_W-1:0]  w_acc_next;

   logic [CNT_W-1:0]  r_cnt;
   logic              r_s1_valid;
   logic              r_s1_last;
   logic [PART_W-1:0] r_s1_sum;
   logic              r_first;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  r_sum_out;
   logic              r_out_valid;

   lane_adder_tree #(
      .NLANES (NLANES),
      .LANE_W (PROD_W)
   ) u_tree (
      .i_lanes (prod_in),
      .o_sum   (w_lane_sum)
   );

   assign w_adv       = !r_out_valid || out_ready;
   assign w_accept    = in_valid && w_adv;
   assign w_beat_last = (r_cnt == CNT_W'(NBEATS - 1));
   assign w_done      = r_s1_valid && r_s1_last;
   assign w_acc_next  = (r_first ? '0 : r_acc) + ACC_W'(r_s1_sum);

   // Stage 1: per-beat lane reduction and beat position tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_sum   <= '0;
      end else if (w_adv) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_sum  <= w_lane_sum;
            r_s1_last <= w_beat_last;
            r_cnt     <= w_beat_last ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

   // Stage 2: accumulate partials; the last one publishes the product and
   // re-arms the accumulator so back-to-back products need no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc       <= '0;
         r_first     <= 1'b1;
         r_sum_out   <= '0;
         r_out_valid <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= w_done;
         if (r_s1_valid) begin
            if (r_s1_last) begin
               r_sum_out <= w_acc_next;
               r_acc     <= '0;
               r_first   <= 1'b1;
            end else begin
               r_acc     <= w_acc_next;
               r_first   <= 1'b0;
            end
         end
      end
   end

   assign in_ready  = w_adv;
   assign sum_out   = r_sum_out;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_scalar_product_acc.sv
// Bench for scalar_product_acc: directed scenarios plus randomized traffic
// against a queue-based model of whole scalar products.
module tb_scalar_product_acc;

   localparam int NBITS  = 4;
   localparam int NLANES = 4;
   localparam int NBEATS = 2;
   localparam int PROD_W = 2 * NBITS;
   localparam int ACC_W  = 11;
   localparam int ACC1_W = 10;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NLANES*PROD_W-1:0] prod_in;
   logic                     in_valid;
   logic                     in_ready;
   logic [ACC_W-1:0]         sum_out;
   logic                     out_valid;
   logic                     out_ready;

   logic [NLANES*PROD_W-1:0] d1_prod_in;
   logic                     d1_in_valid;
   logic                     d1_in_ready;
   logic [ACC1_W-1:0]        d1_sum_out;
   logic                     d1_out_valid;
   logic                     d1_out_ready;

   always #5 clk = ~clk;

   scalar_product_acc #(.NBITS(NBITS), .NLANES(NLANES), .NBEATS(NBEATS)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .prod_in   (prod_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum_out   (sum_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   scalar_product_acc #(.NBITS(NBITS), .NLANES(NLANES), .NBEATS(1)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .prod_in   (d1_prod_in),
      .in_valid  (d1_in_valid),
      .in_ready  (d1_in_ready),
      .sum_out   (d1_sum_out),
      .out_valid (d1_out_valid),
      .out_ready (d1_out_ready)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [ACC_W-1:0] exp_q[$];
   int part_sum   = 0;
   int part_beats = 0;
   logic last_acc = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int lane_sum(input logic [NLANES*PROD_W-1:0] p);
      int s;
      s = 0;
      for (int i = 0; i < NLANES; i++) s += int'(p[i*PROD_W +: PROD_W]);
      return s;
   endfunction

   function automatic logic [NLANES*PROD_W-1:0] pack(input int l3, input int l2, input int l1, input int l0);
      return {PROD_W'(l3), PROD_W'(l2), PROD_W'(l1), PROD_W'(l0)};
   endfunction

   function automatic logic [NLANES*PROD_W-1:0] rand_beat();
      logic [NLANES*PROD_W-1:0] p;
      for (int i = 0; i < NLANES; i++)
         p[i*PROD_W +: PROD_W] = PROD_W'($urandom_range(0, 15) * $urandom_range(0, 15));
      return p;
   endfunction

   // One clock cycle: inputs were set after the previous falling edge.
   task automatic step();
      logic acc, fire, stall, rst;
      logic [ACC_W-1:0] held;
      logic [NLANES*PROD_W-1:0] beat;
      #1;
      rst   = reset;
      acc   = !rst && in_valid && in_ready;
      fire  = !rst && out_valid && out_ready;
      stall = !rst && out_valid && !out_ready;
      held  = sum_out;
      beat  = prod_in;
      last_acc = acc;
      if (!rst) check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (fire) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL result_unexpected: observed %0d expected none", sum_out);
         end else begin
            check("result", sum_out, exp_q.pop_front());
         end
      end
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
         part_sum   = 0;
         part_beats = 0;
      end else if (acc) begin
         part_sum += lane_sum(beat);
         part_beats++;
         if (part_beats == NBEATS) begin
            exp_q.push_back(ACC_W'(part_sum));
            part_sum   = 0;
            part_beats = 0;
         end
      end
      @(negedge clk);
      if (stall) begin
         check("stall_valid", out_valid, 1);
         check("stall_sum", sum_out, held);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum_out", sum_out, 0);
      check("rst_in_ready", in_ready, 1);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (!out_valid && n < budget) begin
         step();
         n++;
      end
      if (!out_valid) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s_timeout: observed no out_valid expected out_valid within %0d cycles", tag, budget);
      end
   endtask

   initial begin
      logic hold;
      logic [NLANES*PROD_W-1:0] b;
      int   s;
      reset = 1'b1;
      prod_in = '0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      d1_prod_in = '0;
      d1_in_valid = 1'b0;
      d1_out_ready = 1'b1;
      @(negedge clk);
      do_reset();

      // Two beats summing to 56; result visible right after the stage-2 edge, for one cycle.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      prod_in   = pack(12, 10, 6, 0);
      step();
      prod_in   = pack(0, 6, 10, 12);
      step();
      in_valid  = 1'b0;
      check("lat_not_early", out_valid, 0);
      step();
      check("lat_valid", out_valid, 1);
      check("lat_sum", sum_out, 56);
      step();
      check("lat_one_cycle", out_valid, 0);
      check("lat_sum_holds", sum_out, 56);

      // Maximum product, no wrap.
      in_valid = 1'b1;
      prod_in  = pack(225, 225, 225, 225);
      step();
      step();
      in_valid = 1'b0;
      wait_valid("max", 5);
      check("max_sum", sum_out, 1800);
      step();

      // Back-to-back products with in_valid held.
      in_valid = 1'b1;
      prod_in  = pack(1, 1, 1, 1);
      step();
      check("b2b_ready0", in_ready, 1);
      step();
      check("b2b_ready1", in_ready, 1);
      prod_in  = pack(2, 2, 2, 2);
      step();
      check("b2b_ready2", in_ready, 1);
      check("b2b_first", sum_out, 8);
      check("b2b_first_valid", out_valid, 1);
      step();
      in_valid = 1'b0;
      check("b2b_ready3", in_ready, 1);
      step();
      check("b2b_second", sum_out, 16);
      check("b2b_second_valid", out_valid, 1);
      step();

      // Backpressure: result held 5 cycles, then one drain cycle, next result follows.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      prod_in   = pack(1, 2, 3, 4);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) prod_in = pack(7, 0, 0, 9);
         step();
      end
      wait_valid("bp", 5);
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", in_ready, 0);
         check("bp_sum", sum_out, 20);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      wait_valid("bp_next", 5);
      check("bp_next_sum", sum_out, 32);
      out_ready = 1'b1;
      step();
      step();

      // Reset mid-product discards beat 0.
      in_valid = 1'b1;
      prod_in  = pack(5, 5, 5, 5);
      step();
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      prod_in   = pack(1, 0, 0, 0);
      step();
      prod_in   = pack(0, 0, 0, 1);
      step();
      in_valid  = 1'b0;
      wait_valid("rst_mid", 5);
      check("rst_mid_sum", sum_out, 2);
      step();

      // Randomized traffic with backpressure and one reset.
      hold = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            do_reset();
            hold = 1'b0;
         end
         if (!hold) begin
            in_valid = ($urandom_range(0, 9) < 7);
            prod_in  = rand_beat();
         end
         out_ready = ($urandom_range(0, 9) < 7);
         step();
         hold = in_valid && !last_acc;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("drained", exp_q.size(), 0);

      // Single-beat build: every beat is its own product.
      for (int i = 0; i < 12; i++) begin
         b = (i == 0) ? pack(225, 225, 225, 225) : rand_beat();
         s = lane_sum(b);
         d1_prod_in  = b;
         d1_in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         d1_in_valid = 1'b0;
         check("nb1_not_early", d1_out_valid, 0);
         @(posedge clk);
         @(negedge clk);
         check("nb1_valid", d1_out_valid, 1);
         check("nb1_sum", d1_sum_out, s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
